udp_reg_client: RTL and testbench

- Initiator end of the UDP register-access protocol (port 0xC0DE); the server-side register bridge is the responder.
- Takes single register read/write commands from a local master (test sequencer, MicroBlaze glue, loopback bench), frames them onto the UDP TX stream and tracks the read reply.
- For a read, it matches the reply from the UDP RX stream and returns read data or an error status.
- Sits between the local master and the 64-bit UDP stack user ports.

---
 rtl/udp_reg_pkg.sv | 59 +++++
 rtl/udp_reg_client.sv | 209 ++++++++++++++++++++
 tb/tb_udp_reg_client.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_reg_pkg.sv
// udp_reg_pkg
// Shared definitions for the UDP register-access protocol (port 0xC0DE):
// default magic word, response status codes, client FSM states, packet
// field positions and the CRC16-CCITT helper used by both ends of the link.
package udp_reg_pkg;

    localparam logic [15:0] MAGIC_DEF = 16'hC0DE;

    // Beat0 field layout
    localparam int MAGIC_LSB    = 48;
    localparam int OP_BIT       = 47;
    localparam int ADDR_LSB     = 32;
    localparam int ADDR_FIELD_W = 15;
    localparam int DATA_W       = 32;
    localparam int CRC_W        = 16;

    localparam logic [7:0] KEEP_HDR = 8'hFF;
    localparam logic [7:0] KEEP_CRC = 8'h03;

    typedef enum logic [1:0] {
        ST_OK            = 2'd0,
        ST_TIMEOUT       = 2'd1,
        ST_CRC_ERR       = 2'd2,
        ST_ADDR_MISMATCH = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_HDR   = 3'd1,
        S_TX_CRC   = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_RX_CRC   = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    // CRC16-CCITT, poly 0x1021, init 0xFFFF, MSB-first over bits 63..0,
    // no final xor.
    function automatic logic [15:0] crc16_ccitt64(input logic [63:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = 16'hFFFF;
        for (int i = 63; i >= 0; i--) begin
            fb  = crc[15] ^ data[i];
            crc = {crc[14:0], 1'b0};
            if (fb) begin
                crc = crc ^ 16'h1021;
            end
        end
        return crc;
    endfunction

    function automatic logic [63:0] build_hdr(input logic [15:0] magic,
                                              input logic        op,
                                              input logic [14:0] addr,
                                              input logic [31:0] data);
        return {magic, op, addr, data};
    endfunction

endpackage

// File: rtl/udp_reg_client.sv
// udp_reg_client
// Initiator side of the UDP register-access protocol. Accepts one register
// read/write command at a time from a local master, sends it as a two-beat
// packet (header + CRC) on the UDP TX stream and, for reads, waits for the
// matching two-beat reply on the RX stream.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/ready         command handshake
//   cmd_write/addr/wdata    command fields (wdata ignored for reads)
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata/rsp_status    read data / completion status (status_e)
//   m_axis_*                64-bit UDP TX payload stream
//   s_axis_*                64-bit UDP RX payload stream (always ready)
module udp_reg_client
    import udp_reg_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          TIMEOUT_CYC = 100000,
    parameter logic [15:0] MAGIC       = MAGIC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [63:0]        tx_hdr_q, tx_hdr_d;
    logic [15:0]        tx_crc_q, tx_crc_d;
    logic [47:0]        rx_hdr_q, rx_hdr_d;   // captured reply beat0 below the magic
    logic [15:0]        rx_crc_q, rx_crc_d;   // CRC of captured reply beat0
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;       // discarding rest of a non-matching packet
    status_e            status_q, status_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               armed_q;              // holds cmd_ready low until first clock after reset

    logic        rx_hdr_ok;
    logic        timeout_hit;
    logic [63:0] cmd_hdr;

    assign cmd_hdr = build_hdr(MAGIC, cmd_write, ADDR_FIELD_W'(cmd_addr),
                               cmd_write ? cmd_wdata : 32'h0);

    assign rx_hdr_ok = s_axis_tvalid && !s_axis_tlast && (s_axis_tkeep == KEEP_HDR) &&
                       (s_axis_tdata[63:MAGIC_LSB] == MAGIC);

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tx_hdr_q <= '0;
            tx_crc_q <= '0;
            rx_hdr_q <= '0;
            rx_crc_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            status_q <= ST_OK;
            rdata_q  <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_hdr_q <= tx_hdr_d;
            tx_crc_q <= tx_crc_d;
            rx_hdr_q <= rx_hdr_d;
            rx_crc_q <= rx_crc_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            armed_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_hdr_d = tx_hdr_q;
        tx_crc_d = tx_crc_q;
        rx_hdr_d = rx_hdr_q;
        rx_crc_d = rx_crc_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        status_d = status_q;
        rdata_d  = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (armed_q && cmd_valid) begin
                    tx_hdr_d = cmd_hdr;
                    tx_crc_d = crc16_ccitt64(cmd_hdr);
                    state_d  = S_TX_HDR;
                end
            end

            S_TX_HDR: begin
                if (m_axis_tready) begin
                    state_d = S_TX_CRC;
                end
            end

            S_TX_CRC: begin
                if (m_axis_tready) begin
                    if (tx_hdr_q[OP_BIT]) begin
                        status_d = ST_OK;
                        rdata_d  = '0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        drop_d  = 1'b0;
                        state_d = S_WAIT_RSP;
                    end
                end
            end

            S_WAIT_RSP: begin
                // Saturate so a capture on the last count still times out later.
                cnt_d = timeout_hit ? cnt_q : cnt_q + 1'b1;
                if (!drop_q && rx_hdr_ok) begin
                    rx_hdr_d = s_axis_tdata[47:0];
                    rx_crc_d = crc16_ccitt64(s_axis_tdata);
                    state_d  = S_RX_CRC;
                end else begin
                    if (s_axis_tvalid) begin
                        drop_d = !s_axis_tlast;
                    end
                    if (timeout_hit) begin
                        status_d = ST_TIMEOUT;
                        rdata_d  = '0;
                        state_d  = S_DONE;
                    end
                end
            end

            S_RX_CRC: begin
                cnt_d = timeout_hit ? cnt_q : cnt_q + 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    rdata_d = '0;
                    state_d = S_DONE;
                    if (s_axis_tdata[CRC_W-1:0] != rx_crc_q) begin
                        status_d = ST_CRC_ERR;
                    end else if (rx_hdr_q[OP_BIT] ||
                                 rx_hdr_q[ADDR_LSB +: ADDR_FIELD_W] !=
                                 tx_hdr_q[ADDR_LSB +: ADDR_FIELD_W]) begin
                        status_d = ST_ADDR_MISMATCH;
                    end else begin
                        status_d = ST_OK;
                        rdata_d  = rx_hdr_q[DATA_W-1:0];
                    end
                end else if (rx_hdr_ok) begin
                    // A new header-looking beat restarts the match.
                    rx_hdr_d = s_axis_tdata[47:0];
                    rx_crc_d = crc16_ccitt64(s_axis_tdata);
                end else begin
                    if (s_axis_tvalid) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT_RSP;
                    end
                    if (timeout_hit) begin
                        status_d = ST_TIMEOUT;
                        rdata_d  = '0;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready     = armed_q && (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_DONE);
    assign rsp_rdata     = (state_q == S_DONE) ? rdata_q : 32'h0;
    assign rsp_status    = (state_q == S_DONE) ? status_q : ST_OK;
    assign m_axis_tvalid = (state_q == S_TX_HDR) || (state_q == S_TX_CRC);
    assign m_axis_tlast  = (state_q == S_TX_CRC);
    assign m_axis_tdata  = (state_q == S_TX_HDR) ? tx_hdr_q :
                           (state_q == S_TX_CRC) ? {48'h0, tx_crc_q} : 64'h0;
    assign m_axis_tkeep  = (state_q == S_TX_HDR) ? KEEP_HDR :
                           (state_q == S_TX_CRC) ? KEEP_CRC : 8'h00;
    assign s_axis_tready = 1'b1;

endmodule

// File: tb/tb_udp_reg_client.sv
module tb_udp_reg_client;

    localparam int          TO    = 64;
    localparam logic [15:0] MAGIC = 16'hC0DE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;

    always #5 clk = ~clk;

    udp_reg_client #(.ADDR_W(8), .TIMEOUT_CYC(TO), .MAGIC(MAGIC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready)
    );

    // ---------------- reference model ----------------
    // CRC as polynomial remainder: (init * x^64 + M * x^16) mod (x^16+x^12+x^5+1)
    function automatic logic [15:0] crc_ref(input logic [63:0] m);
        logic [79:0] r;
        r = {m, 16'h0} ^ {16'hFFFF, 64'h0};
        for (int i = 79; i >= 16; i--) begin
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    function automatic logic [63:0] pkt_hdr(input logic op, input logic [14:0] a, input logic [31:0] d);
        return {MAGIC, op, a, d};
    endfunction

    typedef struct {
        logic [1:0]  st;
        logic [31:0] rd;
        int          kind;   // 0 no latency check, 1 from accept edge, 2 from tx tlast edge, 3 from rx tlast edge
        int          lat;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [72:0] tx_q[$];

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          acc_edge = 0, txl_edge = 0, rxl_edge = 0, txl_cnt = 0, rsp_cnt = 0;
    logic        hold_pend = 1'b0;
    logic [72:0] held;

    always @(negedge clk) begin
        logic [72:0] cur;
        rsp_t        e;
        int          refe;
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rsp: got status %0d rdata %0h, required none", rsp_status, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_status", 128'(rsp_status), 128'(e.st));
                check("rsp_rdata", 128'(rsp_rdata), 128'(e.rd));
                if (e.kind != 0) begin
                    refe = (e.kind == 1) ? acc_edge : (e.kind == 2) ? txl_edge : rxl_edge;
                    check("rsp_latency", 128'(cyc - refe), 128'(e.lat));
                end
                $display("rsp %0d: status %0d rdata %08h at cycle %0d", rsp_cnt, rsp_status, rsp_rdata, cyc);
            end
        end
        if (cmd_valid && cmd_ready) acc_edge = cyc + 1;
        if (m_axis_tvalid) begin
            if (hold_pend) check("tx_hold_stable", 128'(cur), 128'(held));
            if (m_axis_tready) begin
                hold_pend = 1'b0;
                if (tx_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_tx_beat: got %0h, required none", cur);
                end else begin
                    check("tx_beat", 128'(cur), 128'(tx_q.pop_front()));
                end
                if (m_axis_tlast) begin
                    txl_edge = cyc + 1;
                    txl_cnt++;
                end
            end else begin
                held = cur;
                hold_pend = 1'b1;
            end
        end else begin
            hold_pend = 1'b0;
        end
        if (s_axis_tvalid && s_axis_tlast) rxl_edge = cyc + 1;
    end

    // ---------------- tready driver ----------------
    int tr_mode = 0;   // 0 held high, 1 toggle, 2 random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [1:0] st, input logic [31:0] rd, input int kind, input int lat);
        rsp_t e;
        e.st = st; e.rd = rd; e.kind = kind; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
        logic [63:0] h;
        int n;
        h = pkt_hdr(w, {7'h0, a}, w ? d : 32'h0);
        tx_q.push_back({h, 8'hFF, 1'b0});
        tx_q.push_back({48'h0, crc_ref(h), 8'h03, 1'b1});
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 100);
        if (!cmd_ready) begin
            compared++; mismatched++;
            $display("FAIL cmd_accept_timeout: cmd_ready %0b, required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd: write %0b addr %02h wdata %08h", w, a, d);
    endtask

    task automatic send_rx(input logic [63:0] d, input logic [7:0] k, input logic l);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    endtask

    task automatic rx_idle();
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    endtask

    task automatic send_reply(input logic op, input logic [14:0] a, input logic [31:0] d, input logic [15:0] crc_xor);
        logic [63:0] h;
        h = pkt_hdr(op, a, d);
        send_rx(h, 8'hFF, 1'b0);
        send_rx({48'h0, crc_ref(h) ^ crc_xor}, 8'h03, 1'b1);
        rx_idle();
    endtask

    task automatic wait_tx_last(input int prev);
        int n;
        n = 0;
        while (txl_cnt == prev && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (txl_cnt == prev) begin
            compared++; mismatched++;
            $display("FAIL tx_packet_timeout: tlast handshakes %0d, required %0d", txl_cnt, prev + 1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL rsp_timeout: pending %0d responses, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {cmd_ready, rsp_valid, rsp_rdata, rsp_status, m_axis_tvalid, m_axis_tlast,
                     m_axis_tkeep, m_axis_tdata, s_axis_tready},
              {1'b0, 1'b0, 32'h0, 2'h0, 1'b0, 1'b0, 8'h0, 64'h0, 1'b1});
    endtask

    initial begin
        int prev;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d, rd;
        int          k;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 128'(cmd_ready), 128'(1));

        // write, tready high: 4-cycle completion
        tr_mode = 0;
        push_exp(2'd0, 32'h0, 1, 2);
        send_cmd(1'b1, 8'h12, 32'hDEADBEEF);
        wait_done();

        // read with good reply 10 cycles after request
        push_exp(2'd0, 32'h12345678, 3, 0);
        prev = txl_cnt;
        send_cmd(1'b0, 8'h05, 32'hA5A5A5A5);
        wait_tx_last(prev);
        repeat (9) @(posedge clk);
        send_reply(1'b0, 15'h05, 32'h12345678, 16'h0);
        wait_done();

        // read timeout
        push_exp(2'd1, 32'h0, 2, TO);
        send_cmd(1'b0, 8'h05, 32'h0);
        wait_done();

        // CRC error, then address mismatch
        push_exp(2'd2, 32'h0, 3, 0);
        prev = txl_cnt;
        send_cmd(1'b0, 8'h05, 32'h0);
        wait_tx_last(prev);
        send_reply(1'b0, 15'h05, 32'h11112222, 16'h0001);
        wait_done();
        push_exp(2'd3, 32'h0, 3, 0);
        prev = txl_cnt;
        send_cmd(1'b0, 8'h05, 32'h0);
        wait_tx_last(prev);
        send_reply(1'b0, 15'h06, 32'h33334444, 16'h0);
        wait_done();

        // write with toggling tready
        tr_mode = 1;
        push_exp(2'd0, 32'h0, 0, 0);
        send_cmd(1'b1, 8'h7E, 32'h0BADF00D);
        wait_done();
        tr_mode = 0;

        // reset while waiting for a read reply: no response must appear
        prev = txl_cnt;
        send_cmd(1'b0, 8'h05, 32'h0);
        wait_tx_last(prev);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_read");
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_reply(1'b0, 15'h05, 32'h12345678, 16'h0);
        repeat (20) @(posedge clk);
        push_exp(2'd0, 32'h0, 1, 2);
        send_cmd(1'b1, 8'h33, 32'hCAFEBABE);
        wait_done();

        // randomized traffic with random back-pressure
        tr_mode = 2;
        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            d = $urandom;
            if (w) begin
                push_exp(2'd0, 32'h0, 0, 0);
                send_cmd(1'b1, a, d);
            end else begin
                k  = $urandom_range(0, 4);
                rd = $urandom;
                case (k)
                    0: push_exp(2'd0, rd, 3, 0);
                    1, 2, 3: push_exp(2'(k + 1 == 4 ? 3 : k + 1), 32'h0, 3, 0);
                    default: push_exp(2'd1, 32'h0, 2, TO);
                endcase
                prev = txl_cnt;
                send_cmd(1'b0, a, d);
                wait_tx_last(prev);
                repeat ($urandom_range(0, 20)) @(posedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    // stray packet: bad magic, then a header-looking beat, then tlast
                    send_rx({16'hBEEF, 48'h0}, 8'hFF, 1'b0);
                    send_rx(pkt_hdr(1'b0, {7'h0, a}, 32'hFFFFFFFF), 8'hFF, 1'b0);
                    send_rx(64'h0, 8'h03, 1'b1);
                    rx_idle();
                end
                case (k)
                    0: send_reply(1'b0, {7'h0, a}, rd, 16'h0);
                    1: send_reply(1'b0, {7'h0, a}, rd, 16'(1 << $urandom_range(0, 15)));
                    2: send_reply(1'b0, {7'h0, a ^ 8'($urandom_range(1, 255))}, rd, 16'h0);
                    3: send_reply(1'b1, {7'h0, a}, rd, 16'h0);
                    default: ;
                endcase
            end
            wait_done();
        end

        check("scoreboard_drained", 128'(exp_q.size() + tx_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
